// File: rtl/if_stage.sv
// if_stage: instruction fetch with req/ack memory handshake, redirect handling and IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        control_j,
    input  logic [31:0] pc_j,
    output logic [31:0] pipe_pc,
    output logic [31:0] pipe_data,
    output logic        pipe_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_req_addr, w_req_addr_nx;
    logic        r_busy, w_busy_nx;
    logic        r_kill, w_kill_nx;
    logic [31:0] r_hold_pc, w_hold_pc_nx;
    logic [31:0] r_hold_inst, w_hold_inst_nx;
    logic [31:0] r_pipe_pc, w_pipe_pc_nx;
    logic [31:0] r_pipe_data, w_pipe_data_nx;
    logic        r_pipe_valid, w_pipe_valid_nx;

    logic        w_fetching;
    logic        w_redirect;
    logic        w_accept;
    logic        w_bubble;
    logic [31:0] w_addr;

    assign w_fetching = (r_state == S_FETCH);
    assign w_redirect = control_j & r_pipe_valid & ~stall;
    // r_busy marks a request already in flight whose address must not move
    assign w_addr     = r_busy ? r_req_addr : r_pc;

    assign imem_req   = w_fetching & ~reset;
    assign imem_addr  = w_addr;
    assign pipe_pc    = r_pipe_pc;
    assign pipe_data  = r_pipe_data;
    assign pipe_valid = r_pipe_valid;

    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_req_addr_nx   = r_req_addr;
        w_busy_nx       = r_busy;
        w_kill_nx       = r_kill;
        w_hold_pc_nx    = r_hold_pc;
        w_hold_inst_nx  = r_hold_inst;
        w_pipe_pc_nx    = r_pipe_pc;
        w_pipe_data_nx  = r_pipe_data;
        w_pipe_valid_nx = r_pipe_valid;
        w_accept        = 1'b0;
        w_bubble        = 1'b0;

        if (w_redirect) begin
            w_pc_nx    = pc_j;
            w_state_nx = S_FETCH;
            w_bubble   = 1'b1;
            // an unanswered request cannot be withdrawn, so its answer gets killed
            if (w_fetching && !imem_ack) begin
                w_kill_nx     = 1'b1;
                w_busy_nx     = 1'b1;
                w_req_addr_nx = w_addr;
            end else begin
                w_kill_nx = 1'b0;
                w_busy_nx = 1'b0;
            end
        end else if (w_fetching) begin
            if (imem_ack) begin
                w_busy_nx = 1'b0;
                if (r_kill) begin
                    w_kill_nx = 1'b0;
                    w_bubble  = ~stall;
                end else begin
                    w_accept = 1'b1;
                    w_pc_nx  = w_addr + PC_STEP;
                    if (stall) begin
                        w_hold_pc_nx   = w_addr;
                        w_hold_inst_nx = imem_rdata;
                        w_state_nx     = S_HOLD;
                    end else begin
                        w_pipe_pc_nx    = w_addr;
                        w_pipe_data_nx  = imem_rdata;
                        w_pipe_valid_nx = 1'b1;
                    end
                end
            end else begin
                w_busy_nx     = 1'b1;
                w_req_addr_nx = w_addr;
                w_bubble      = ~stall;
            end
        end else if (!stall) begin
            w_pipe_pc_nx    = r_hold_pc;
            w_pipe_data_nx  = r_hold_inst;
            w_pipe_valid_nx = 1'b1;
            w_state_nx      = S_FETCH;
        end

        if (w_bubble) begin
            w_pipe_valid_nx = 1'b0;
            w_pipe_data_nx  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_busy       <= 1'b0;
            r_kill       <= 1'b0;
            r_hold_pc    <= RESET_PC;
            r_hold_inst  <= NOP_INST;
            r_pipe_pc    <= RESET_PC;
            r_pipe_data  <= NOP_INST;
            r_pipe_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_req_addr   <= w_req_addr_nx;
            r_busy       <= w_busy_nx;
            r_kill       <= w_kill_nx;
            r_hold_pc    <= w_hold_pc_nx;
            r_hold_inst  <= w_hold_inst_nx;
            r_pipe_pc    <= w_pipe_pc_nx;
            r_pipe_data  <= w_pipe_data_nx;
            r_pipe_valid <= w_pipe_valid_nx;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_accept) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage (zero-wait, latency, stall, redirect, reset, PC wrap).
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, reset_w;
    logic        stall, control_j;
    logic [31:0] pc_j;
    logic        zw, man_ack;

    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pipe_pc, pipe_data;
    logic        pipe_valid;

    logic        req_w, ack_w;
    logic [31:0] addr_w, rdata_w;
    logic [31:0] ppc_w, pdata_w;
    logic        pvalid_w;
    logic        stall_w = 1'b0;
    logic        cj_w = 1'b0;
    logic [31:0] pcj_w = 32'd0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt_w, bubble_cnt_w;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_ack   = zw ? imem_req : man_ack;
    assign imem_rdata = imem_addr + 32'h100;
    assign ack_w      = req_w;
    assign rdata_w    = addr_w + 32'h100;

    if_stage u_dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .control_j  (control_j),
        .pc_j       (pc_j),
        .pipe_pc    (pipe_pc),
        .pipe_data  (pipe_data),
        .pipe_valid (pipe_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk        (clk),
        .reset      (reset_w),
        .imem_req   (req_w),
        .imem_addr  (addr_w),
        .imem_ack   (ack_w),
        .imem_rdata (rdata_w),
        .stall      (stall_w),
        .control_j  (cj_w),
        .pc_j       (pcj_w),
        .pipe_pc    (ppc_w),
        .pipe_data  (pdata_w),
        .pipe_valid (pvalid_w)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt_w),
        .bubble_cnt (bubble_cnt_w)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; reset_w = 1'b1; stall = 1'b0; control_j = 1'b0;
        pc_j = 32'd0; zw = 1'b0; man_ack = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, pipe_valid}, 32'd0);
        chk("rst_data", pipe_data, 32'h13);
        chk("rst_pc", pipe_pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        // zero-wait stream
        reset = 1'b0; zw = 1'b1; #1;
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_valid", {31'd0, pipe_valid}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("zw_pc", pipe_pc, 32'(4 * i));
            chk("zw_data", pipe_data, 32'h100 + 32'(4 * i));
            chk("zw_valid", {31'd0, pipe_valid}, 32'd1);
            tick();
        end

        // 3-cycle latency on address 0x14
        zw = 1'b0; #1;
        chk("lat_addr0", imem_addr, 32'h14);
        chk("lat_req0", {31'd0, imem_req}, 32'd1);
        tick();
        chk("lat_b1_valid", {31'd0, pipe_valid}, 32'd0);
        chk("lat_b1_data", pipe_data, 32'h13);
        chk("lat_b1_pc", pipe_pc, 32'h10);
        chk("lat_addr1", imem_addr, 32'h14);
        tick();
        chk("lat_b2_valid", {31'd0, pipe_valid}, 32'd0);
        chk("lat_addr2", imem_addr, 32'h14);
        man_ack = 1'b1;
        tick();
        chk("lat_pc", pipe_pc, 32'h14);
        chk("lat_data", pipe_data, 32'h114);
        chk("lat_valid", {31'd0, pipe_valid}, 32'd1);
        chk("lat_next_addr", imem_addr, 32'h18);

        // stall for 4 cycles while 0x18 is acknowledged
        stall = 1'b1; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("hold_req1", {31'd0, imem_req}, 32'd0);
        chk("hold_pc1", pipe_pc, 32'h14);
        chk("hold_valid1", {31'd0, pipe_valid}, 32'd1);
        tick();
        chk("hold_req2", {31'd0, imem_req}, 32'd0);
        chk("hold_pc2", pipe_pc, 32'h14);
        tick();
        tick();
        chk("hold_data4", pipe_data, 32'h114);
        chk("hold_req4", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk("rel_pc", pipe_pc, 32'h18);
        chk("rel_data", pipe_data, 32'h118);
        chk("rel_valid", {31'd0, pipe_valid}, 32'd1);
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h1C);

        // reset in the middle of the 0x1C request, with a stray ack
        reset = 1'b1; man_ack = 1'b1; #1;
        chk("rst2_req_during", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rst2_valid", {31'd0, pipe_valid}, 32'd0);
        chk("rst2_data", pipe_data, 32'h13);
        chk("rst2_pc", pipe_pc, 32'h0);
        reset = 1'b0; man_ack = 1'b0; #1;
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_req", {31'd0, imem_req}, 32'd1);

        // redirect to 0x40 while the 0x8 request is outstanding
        zw = 1'b1;
        tick(); tick();
        chk("pre_rd_pc", pipe_pc, 32'h4);
        chk("pre_rd_valid", {31'd0, pipe_valid}, 32'd1);
        zw = 1'b0; control_j = 1'b1; pc_j = 32'h40; #1;
        chk("rd_addr0", imem_addr, 32'h8);
        tick();
        control_j = 1'b0;
        chk("rd_valid", {31'd0, pipe_valid}, 32'd0);
        chk("rd_data", pipe_data, 32'h13);
        chk("rd_pc", pipe_pc, 32'h4);
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        chk("rd_addr1", imem_addr, 32'h8);
        tick();
        chk("rd_addr2", imem_addr, 32'h8);
        man_ack = 1'b1;
        tick();
        chk("rd_kill_valid", {31'd0, pipe_valid}, 32'd0);
        chk("rd_new_addr", imem_addr, 32'h40);
        tick();
        chk("rd_first_pc", pipe_pc, 32'h40);
        chk("rd_first_data", pipe_data, 32'h140);
        chk("rd_first_valid", {31'd0, pipe_valid}, 32'd1);

        // redirect to 0x80 in the same cycle as the ack for 0x44
        control_j = 1'b1; pc_j = 32'h80;
        tick();
        control_j = 1'b0;
        chk("rj_valid", {31'd0, pipe_valid}, 32'd0);
        chk("rj_pc", pipe_pc, 32'h40);
        chk("rj_addr", imem_addr, 32'h80);
        tick();
        chk("rj_first_pc", pipe_pc, 32'h80);
        chk("rj_first_data", pipe_data, 32'h180);
        chk("rj_first_valid", {31'd0, pipe_valid}, 32'd1);

        // PC wrap on the second instance
        man_ack = 1'b0; reset_w = 1'b0; #1;
        chk("w_addr0", addr_w, 32'hFFFF_FFF8);
        chk("w_req0", {31'd0, req_w}, 32'd1);
        tick();
        chk("w_pc0", ppc_w, 32'hFFFF_FFF8);
        chk("w_data0", pdata_w, 32'h0000_00F8);
        chk("w_addr1", addr_w, 32'hFFFF_FFFC);
        tick();
        chk("w_pc1", ppc_w, 32'hFFFF_FFFC);
        chk("w_addr2", addr_w, 32'h0);
        tick();
        chk("w_pc2", ppc_w, 32'h0);
        chk("w_data2", pdata_w, 32'h100);
        chk("w_valid2", {31'd0, pvalid_w}, 32'd1);
`ifdef IF_PERF_CNT_EN
        chk("w_fetch_cnt", fetch_cnt_w, 32'd3);
        chk("w_bubble_cnt", bubble_cnt_w, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
